ip_rx_deframer: RTL and testbench
=================================

// Module: ip_rx_deframer
// PURPOSE
// - Receive-side stage directly upstream of the IP layer. Collects a byte stream (valid/ready/last)
//   into one wide IPv4+TCP frame and validates the IPv4 header in flight.
// - Delivers the frame on frame_data with a valid/ready handshake; that bus feeds the IP layer's rx_ip_data.
// - Frames that fail a check are dropped and counted, and an error code is reported.
// PARAMETERS
// PAYLOAD_LEN  262            TCP payload bytes per frame
// TCPH_LEN     20             TCP header bytes
// IPH_LEN      20             IPv4 header bytes (IHL=5 only)
// PROTOCOL     6              required IPv4 protocol field
// DESADDR      32'h7f000001   required destination address
// FRAME_LEN    PAYLOAD_LEN+TCPH_LEN+IPH_LEN (localparam, 302)
// PORTS
// clk          in   1             clock, all state updates on rising edge
// rst          in   1             asynchronous, active-high reset
// s_data       in   8             stream byte; the first byte on the wire is frame byte 0
// s_valid      in   1             s_data valid
// s_last       in   1             s_data is the final byte of the frame
// s_ready      out  1             byte accepted when s_valid&&s_ready
// frame_data   out  FRAME_LEN*8   frame byte k at bits [8k+7:8k]
// frame_valid  out  1             frame_data holds a validated frame
// frame_ready  in   1             consumer accepts the frame when frame_valid&&frame_ready
// err_pulse    out  1             one-cycle strobe: frame dropped
// err_code     out  3             drop reason, valid with err_pulse (held until the next error)
// drop_cnt     out  16            dropped-frame count, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset values: state RECV, byte count 0, frame_data 0, frame_valid 0, err_pulse 0,
//   err_code 0, drop_cnt 0. s_ready is 0 while rst is asserted.
// - Reset mid-operation discards any partial or held frame.
// - States:
//   - RECV: s_ready=1. Each accepted byte is written to slot cnt and cnt increments.
//   - HOLD: s_ready=0. frame_valid=1 and frame_data is held stable.
//     Leave for RECV on frame_valid&&frame_ready; s_ready rises the following cycle.
//   - DRAIN: s_ready=1. Accepted bytes are discarded. Return to RECV after accepting s_last; cnt is cleared.
// - Header words: word k = {byte[2k+1], byte[2k]} for k=0..9.
//   - Checksum is a one's-complement sum over words 0..9, accumulated as each odd byte lands,
//     using a 17-bit add with end-around carry.
//   - The header passes when the final sum == 16'hFFFF.
// - Header checks are evaluated on the final accepted byte. First match, by priority, sets err_code:
//   - 1 SHORT: s_last with cnt < FRAME_LEN-1
//   - 2 LONG: byte FRAME_LEN-1 accepted without s_last. Report the error, then go to DRAIN.
//   - 3 VER: byte0[3:0]!=4 or byte0[7:4]!=5
//   - 4 LEN: word1 != FRAME_LEN
//   - 5 CSUM: one's-complement sum != 16'hFFFF
//   - 6 PROTO: byte9 != PROTOCOL
//   - 7 DST: bytes 16..19 (bits [159:128]) != DESADDR
// - Pass: go to HOLD. frame_valid rises on the cycle after the last byte is accepted (latency 1 cycle).
// - Fail: err_pulse=1 for exactly one cycle, on the cycle after the offending byte.
//   drop_cnt increments (saturating), frame_valid stays 0, and cnt/accumulator clear to 0.
//   A new frame may start on the next cycle (SHORT/header errors) or after the drain (LONG).
// - Single-byte frame (s_last on byte 0) reports SHORT.
// - s_last is ignored except on accepted beats.
// TESTING
// - Good frame, 302 bytes:
//   - stimulus: byte0=8'h54, bytes2/3=8'h2E/8'h01, byte9=8'h06, bytes16..19=01,00,00,7F,
//     correct checksum, s_last on byte 301
//   - response: frame_valid=1 the next cycle; frame_data matches input; err_pulse never asserts.
// - Same frame with byte 10 XOR 8'h01 -> err_code=5, err_pulse 1 cycle, drop_cnt=1, frame_valid stays 0.
// - s_last on byte 99 -> err_code=1. The next good frame is delivered with no extra idle cycles.
// - 310 bytes with s_last on byte 309 -> err_code=2 after byte 301, remainder drained,
//   the following good frame passes, drop_cnt=1.
// - Good frame with frame_ready held low 10 cycles:
//   - s_ready=0 and frame_data stable throughout; handshake on cycle 11; s_ready=1 the cycle after.
// - rst pulsed mid-frame at byte 50 -> all outputs return to reset values; the next full good frame is delivered.

Source files
------------

// File: rtl/ip_rx_deframer.sv
// Receive deframer: gathers a byte stream into one IPv4+TCP frame, validates the IPv4
// header while the bytes arrive, and either presents the frame or drops and counts it.
module ip_rx_deframer #(
   parameter int          PAYLOAD_LEN = 262,
   parameter int          TCPH_LEN    = 20,
   parameter int          IPH_LEN     = 20,
   parameter int          PROTOCOL    = 6,
   parameter logic [31:0] DESADDR     = 32'h7f00_0001,
   localparam int         FRAME_LEN   = PAYLOAD_LEN + TCPH_LEN + IPH_LEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [FRAME_LEN*8-1:0] frame_data,
   output logic                   frame_valid,
   input  logic                   frame_ready,
   output logic                   err_pulse,
   output logic [2:0]             err_code,
   output logic [15:0]            drop_cnt
);

   localparam int               CNT_W    = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] HDR_LEN  = CNT_W'(IPH_LEN);
   localparam logic [15:0]      LEN16    = 16'(FRAME_LEN);
   localparam logic [7:0]       PROTO8   = 8'(PROTOCOL);

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_SHORT = 3'd1;
   localparam logic [2:0] ERR_LONG  = 3'd2;
   localparam logic [2:0] ERR_VER   = 3'd3;
   localparam logic [2:0] ERR_LEN   = 3'd4;
   localparam logic [2:0] ERR_CSUM  = 3'd5;
   localparam logic [2:0] ERR_PROTO = 3'd6;
   localparam logic [2:0] ERR_DST   = 3'd7;

   typedef enum logic [1:0] {S_RECV, S_HOLD, S_DRAIN} state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [15:0]            acc_q;
   logic [7:0]             lo_q;
   logic [FRAME_LEN*8-1:0] frame_q;
   logic                   fvld_q;
   logic                   err_pulse_q;
   logic [2:0]             err_code_q;
   logic [15:0]            drop_q;

   logic                   accept;
   logic                   at_end;
   logic                   done;
   logic [16:0]            sum17;
   logic [15:0]            acc_d;
   logic [2:0]             err_d;

   assign s_ready = !rst && (state_q != S_HOLD);
   assign accept  = s_valid && s_ready;
   assign at_end  = (cnt_q == LAST_IDX);
   assign done    = s_last || at_end;

   // Header word = {odd byte, even byte}; end-around carry keeps the sum one's-complement.
   assign sum17 = {1'b0, acc_q} + {1'b0, s_data, lo_q};
   assign acc_d = sum17[15:0] + {15'd0, sum17[16]};

   // Only meaningful on the final accepted byte; all header bytes are already stored.
   always_comb begin
      err_d = ERR_NONE;
      if (s_last && !at_end)                              err_d = ERR_SHORT;
      else if (!s_last && at_end)                         err_d = ERR_LONG;
      else if (frame_q[3:0] != 4'd4 || frame_q[7:4] != 4'd5) err_d = ERR_VER;
      else if (frame_q[31:16] != LEN16)                   err_d = ERR_LEN;
      else if (acc_q != 16'hFFFF)                         err_d = ERR_CSUM;
      else if (frame_q[79:72] != PROTO8)                  err_d = ERR_PROTO;
      else if (frame_q[159:128] != DESADDR)               err_d = ERR_DST;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RECV;
         cnt_q       <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         frame_q     <= '0;
         fvld_q      <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         drop_q      <= '0;
      end else begin
         err_pulse_q <= 1'b0;
         case (state_q)
            S_RECV: begin
               if (accept) begin
                  frame_q[{cnt_q, 3'b000} +: 8] <= s_data;
                  if (!cnt_q[0])             lo_q  <= s_data;
                  else if (cnt_q < HDR_LEN)  acc_q <= acc_d;
                  if (done) begin
                     cnt_q <= '0;
                     acc_q <= '0;
                     if (err_d == ERR_NONE) begin
                        state_q <= S_HOLD;
                        fvld_q  <= 1'b1;
                     end else begin
                        err_pulse_q <= 1'b1;
                        err_code_q  <= err_d;
                        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                        if (err_d == ERR_LONG)  state_q <= S_DRAIN;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            S_HOLD: begin
               if (frame_ready) begin
                  fvld_q  <= 1'b0;
                  state_q <= S_RECV;
               end
            end
            S_DRAIN: begin
               if (accept && s_last) state_q <= S_RECV;
            end
            default: state_q <= S_RECV;
         endcase
      end
   end

   assign frame_data  = frame_q;
   assign frame_valid = fvld_q;
   assign err_pulse   = err_pulse_q;
   assign err_code    = err_code_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ip_rx_deframer.sv
// Scoreboard bench for ip_rx_deframer: stimulus pushes expected frames/errors,
// a negedge monitor pops and compares whenever the DUT hands over a frame or an error.
`timescale 1ns/1ps
module tb_ip_rx_deframer;
   localparam int FL = 302;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      s_data = 8'h00;
   logic            s_valid = 1'b0;
   logic            s_last = 1'b0;
   logic            s_ready;
   logic [FL*8-1:0] frame_data;
   logic            frame_valid;
   logic            frame_ready = 1'b1;
   logic            err_pulse;
   logic [2:0]      err_code;
   logic [15:0]     drop_cnt;

   always #5 clk = ~clk;

   ip_rx_deframer dut (
      .clk         (clk),
      .rst         (rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .err_pulse   (err_pulse),
      .err_code    (err_code),
      .drop_cnt    (drop_cnt)
   );

   typedef struct packed {
      logic [2:0]  code;
      logic [15:0] drop;
   } err_t;

   logic [FL*8-1:0] exp_frames[$];
   err_t            exp_errs[$];
   int              n_cmp = 0;
   int              n_bad = 0;
   int              exp_drop = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic void check_frame(string name, logic [FL*8-1:0] act, logic [FL*8-1:0] exp);
      int first;
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         first = 0;
         for (int k = FL - 1; k >= 0; k--)
            if (act[8*k +: 8] !== exp[8*k +: 8]) first = k;
         $display("FAIL %s: byte %0d got %0h, expected %0h", name, first,
                  act[8*first +: 8], exp[8*first +: 8]);
      end
   endfunction

   function automatic logic [FL*8-1:0] fix_csum(logic [FL*8-1:0] f);
      logic [16:0] s;
      s = '0;
      f[95:80] = 16'h0000;
      for (int k = 0; k < 10; k++) begin
         s = {1'b0, s[15:0]} + {1'b0, f[16*k +: 16]};
         s = {1'b0, s[15:0] + {15'd0, s[16]}};
      end
      f[95:80] = ~s[15:0];
      return f;
   endfunction

   function automatic logic [FL*8-1:0] base_frame(int seed);
      logic [FL*8-1:0] f;
      for (int k = 0; k < FL; k++) f[8*k +: 8] = 8'(k * 7 + seed * 13 + 3);
      f[7:0]     = 8'h54;
      f[23:16]   = 8'h2E;
      f[31:24]   = 8'h01;
      f[79:72]   = 8'h06;
      f[159:128] = 32'h7F00_0001;
      return fix_csum(f);
   endfunction

   task automatic expect_err(input int code);
      err_t e;
      if (exp_drop < 65535) exp_drop++;
      e.code = 3'(code);
      e.drop = 16'(exp_drop);
      exp_errs.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, inout int stalls);
      int n;
      n = 0;
      s_data  = b;
      s_valid = 1'b1;
      s_last  = last;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         n++;
         if (n > 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: s_ready=0 for %0d cycles, expected 1", n);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      stalls += n;
   endtask

   task automatic send_frame(input logic [FL*8-1:0] f, input int n, output int stalls);
      logic [7:0] b;
      stalls = 0;
      for (int k = 0; k < n; k++) begin
         if (k < FL) b = f[8*k +: 8];
         else        b = 8'(k);
         send_byte(b, k == n - 1, stalls);
      end
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (frame_valid && frame_ready) begin
               if (exp_frames.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_frame: frame handshake seen, none expected");
               end else begin
                  check_frame("frame_data", frame_data, exp_frames.pop_front());
               end
            end
            if (err_pulse) begin
               if (exp_errs.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_err: err_pulse=1 code %0d, none expected", err_code);
               end else begin
                  err_t e;
                  e = exp_errs.pop_front();
                  check("err_code", 32'(err_code), 32'(e.code));
                  check("drop_cnt", 32'(drop_cnt), 32'(e.drop));
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [FL*8-1:0] f;
      logic [FL*8-1:0] g;
      int              st;
      int              codes[6];
      int              lens[6];

      repeat (2) @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_frame_valid", 32'(frame_valid), 0);
      check("rst_err_pulse", 32'(err_pulse), 0);
      check("rst_err_code", 32'(err_code), 0);
      check("rst_drop_cnt", 32'(drop_cnt), 0);
      check_frame("rst_frame_data", frame_data, '0);
      @(posedge clk);
      #1 rst = 1'b0;

      f = base_frame(1);
      exp_frames.push_back(f);
      send_frame(f, FL, st);
      @(negedge clk);
      check("good_latency_valid", 32'(frame_valid), 1);

      g = f;
      g[87:80] = g[87:80] ^ 8'h01;
      expect_err(5);
      send_frame(g, FL, st);
      @(negedge clk);
      check("csum_frame_valid", 32'(frame_valid), 0);

      expect_err(1);
      send_frame(f, 100, st);
      g = base_frame(2);
      exp_frames.push_back(g);
      send_frame(g, FL, st);
      check("short_next_stalls", 32'(st), 0);

      codes = '{1, 3, 3, 4, 6, 7};
      lens  = '{1, FL, FL, FL, FL, FL};
      for (int c = 0; c < 6; c++) begin
         g = base_frame(10 + c);
         case (c)
            1: g[7:0]     = 8'h45;
            2: g[7:0]     = 8'h55;
            3: g[31:16]   = 16'h012D;
            4: g[79:72]   = 8'h11;
            5: g[159:152] = 8'h7E;
            default: ;
         endcase
         g = fix_csum(g);
         expect_err(codes[c]);
         send_frame(g, lens[c], st);
      end

      f = base_frame(3);
      exp_frames.push_back(f);
      frame_ready = 1'b0;
      send_frame(f, FL, st);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_s_ready", 32'(s_ready), 0);
         check("hold_frame_valid", 32'(frame_valid), 1);
         check_frame("hold_frame_data", frame_data, f);
      end
      @(posedge clk);
      #1 frame_ready = 1'b1;
      @(negedge clk);
      check("hs_cycle_s_ready", 32'(s_ready), 0);
      @(negedge clk);
      check("after_hs_s_ready", 32'(s_ready), 1);
      check("after_hs_frame_valid", 32'(frame_valid), 0);

      f = base_frame(4);
      st = 0;
      for (int k = 0; k < 50; k++) send_byte(f[8*k +: 8], 1'b0, st);
      rst = 1'b1;
      exp_drop = 0;
      @(negedge clk);
      check("midrst_s_ready", 32'(s_ready), 0);
      check("midrst_frame_valid", 32'(frame_valid), 0);
      check("midrst_err_code", 32'(err_code), 0);
      check("midrst_drop_cnt", 32'(drop_cnt), 0);
      check_frame("midrst_frame_data", frame_data, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_frames.push_back(f);
      send_frame(f, FL, st);

      f = base_frame(5);
      expect_err(2);
      send_frame(f, 310, st);
      g = base_frame(6);
      exp_frames.push_back(g);
      send_frame(g, FL, st);
      @(negedge clk);
      check("long_drop_cnt", 32'(drop_cnt), 1);

      for (int i = 0; i < 20 && (exp_frames.size() != 0 || exp_errs.size() != 0); i++)
         @(negedge clk);
      check("sb_frames_left", 32'(exp_frames.size()), 0);
      check("sb_errs_left", 32'(exp_errs.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
